// File: rtl/cla_seq_adder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : cla_seq_adder_pkg
// Shared constants, FSM state type and index-width helper for cla_seq_adder.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package cla_seq_adder_pkg;

  localparam int CHUNK_W = 16;
  localparam int GROUP_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // A one-chunk build still needs a 1-bit index register.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cla_seq_adder_cla16.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : cla16_chunk
// 16-bit two-level carry-lookahead adder; c15 tap present with OVF_DETECT_EN.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module cla16_chunk
  import cla_seq_adder_pkg::*;
(
  input  logic [CHUNK_W-1:0] x,
  input  logic [CHUNK_W-1:0] y,
  input  logic               cin,
  output logic [CHUNK_W-1:0] s,
  output logic               cout,
  output logic               c15
);

  localparam int NGRP = CHUNK_W / GROUP_W;

  logic [CHUNK_W-1:0] w_g;
  logic [CHUNK_W-1:0] w_p;
  logic [NGRP-1:0]    w_gg;
  logic [NGRP-1:0]    w_gp;
  logic [NGRP:0]      w_gc;
  logic [CHUNK_W:0]   w_c;

  assign w_g = x & y;
  assign w_p = x ^ y;

  generate
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
      localparam int B = gi * GROUP_W;
      assign w_gg[gi] = w_g[B+3]
                      | (w_p[B+3] & w_g[B+2])
                      | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                      | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
      assign w_gp[gi] = &w_p[B+3:B];

      assign w_c[B]   = w_gc[gi];
      assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[gi]);
      assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B])
                      | (w_p[B+1] & w_p[B] & w_gc[gi]);
      assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1])
                      | (w_p[B+2] & w_p[B+1] & w_g[B])
                      | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[gi]);
    end
  endgenerate

  // Second-level lookahead: group carries come straight from cin, no ripple.
  assign w_gc[0] = cin;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & cin);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & cin);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & cin);
  assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                 | (&w_gp & cin);
  assign w_c[CHUNK_W] = w_gc[NGRP];

  assign s    = w_p ^ w_c[CHUNK_W-1:0];
  assign cout = w_c[CHUNK_W];

`ifdef OVF_DETECT_EN
  assign c15 = w_c[CHUNK_W-1];
`else
  assign c15 = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/cla_seq_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : cla_seq_adder
// Sequential WIDTH-bit add/sub over one 16-bit CLA, LSB chunk first.
// Optional signed overflow flag: define OVF_DETECT_EN.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module cla_seq_adder
  import cla_seq_adder_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK_W;
  localparam int IDX_W  = idx_width(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               done_q, done_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [CHUNK_W-1:0] w_x, w_y, w_s;
  logic               w_cout;
`ifdef OVF_DETECT_EN
  logic               w_c15;
`else
  logic               w_unused_c15;
`endif

  assign w_x = opa_q[idx_q*CHUNK_W +: CHUNK_W];
  assign w_y = opb_q[idx_q*CHUNK_W +: CHUNK_W];

  cla16_chunk u_cla (
    .x    (w_x),
    .y    (w_y),
    .cin  (carry_q),
    .s    (w_s),
    .cout (w_cout),
`ifdef OVF_DETECT_EN
    .c15  (w_c15)
`else
    .c15  (w_unused_c15)
`endif
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b ^ {WIDTH{sub}};
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*CHUNK_W +: CHUNK_W] = w_s;
        carry_d = w_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cout_d  = w_cout;
          idx_d   = '0;
`ifdef OVF_DETECT_EN
          ovf_d   = w_c15 ^ w_cout;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_seq_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_cla_seq_adder
// Directed table-driven bench for cla_seq_adder (WIDTH=64), OVF_DETECT_EN aware.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_cla_seq_adder;

`ifdef OVF_DETECT_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        busy, done, cout, ovf;
  logic [63:0] sum;

  int checks = 0;
  int errors = 0;

  cla_seq_adder #(.WIDTH(64)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [63:0] ta, input logic [63:0] tb, input logic ts);
    @(negedge clk);
    a = ta; b = tb; sub = ts; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  vec_t vecs[7];
  int   cyc;
  int   pulses;

  initial begin
    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[1] = '{64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                64'h2222_2222_2222_2211, 1'b0, 1'b0};
    vecs[5] = '{64'h0, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[6] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sum", sum, 0);
    check("reset_cout", cout, 0);
    check("reset_ovf", ovf, 0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sub);
      check($sformatf("v%0d_busy", i), busy, 1);
      wait_done(cyc);
      check($sformatf("v%0d_latency", i), cyc, 4);
      check($sformatf("v%0d_sum", i), sum, vecs[i].sum);
      check($sformatf("v%0d_cout", i), cout, vecs[i].cout);
      check($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf & OVF_ON);
      check($sformatf("v%0d_busy_end", i), busy, 0);
      @(posedge clk);
      #1 check($sformatf("v%0d_hold", i), sum, vecs[i].sum);
    end

    // Start while busy must be ignored.
    issue(64'd1, 64'd2, 1'b0);
    @(posedge clk);
    @(negedge clk);
    a = 64'd9; b = 64'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        pulses++;
        check("ignore_sum", sum, 64'd3);
      end
    end
    check("ignore_pulses", pulses, 1);

    // Asynchronous reset after the second chunk edge.
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_sum", sum, 0);
    @(negedge clk) rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1 if (done === 1'b1) pulses++;
    end
    check("rst_no_done", pulses, 0);
    issue(64'd10, 64'd20, 1'b0);
    wait_done(cyc);
    check("post_rst_latency", cyc, 4);
    check("post_rst_sum", sum, 64'd30);

    // Back-to-back: start accepted in the done cycle.
    @(posedge clk);
    #1;
    issue(64'd5, 64'd6, 1'b0);
    wait_done(cyc);
    check("b2b_first_sum", sum, 64'd11);
    a = 64'd100; b = 64'd1; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b_done_fall", done, 0);
    check("b2b_busy_rise", busy, 1);
    wait_done(cyc);
    check("b2b_latency", cyc, 4);
    check("b2b_sum", sum, 64'd101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle wide adder/subtractor controller that sequences a 16-bit two-level carry-lookahead datapath over a WIDTH-bit operand pair, one 16-bit chunk per clock, least-significant chunk first, rippling the chunk carry through a carry register. It sits in the arithmetic datapath as the shared wide-add resource. It accepts one operation at a time with a start/busy/done handshake, which trades latency for a single 16-bit lookahead adder instance.

## Interface
- WIDTH, 64: operand/result width. Must be a multiple of 16 and ≥16.
- NCHUNK, WIDTH/16: derived chunk count. Not user-overridable.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  operation request; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a−b (computed as a + ~b + 1); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH−1 (for sub: 1 = no borrow).
- ovf  output  1  signed overflow (see Configuration).

## Operation
- Reset (async assert): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, chunk index=0, carry register=0. Any in-flight operation is aborted with no done pulse.
- States:
  - IDLE
  - RUN
- IDLE:
  - done is cleared on every edge unless it is the completing edge.
  - If start=1: latch a, latch b XOR {WIDTH{sub}}, set carry=sub, set idx=0, set busy=1, then go to RUN.
- RUN, each edge:
  - Chunk idx = opA[16·idx+15:16·idx] + opB[...] + carry is computed combinationally by the CLA sub-module.
  - The result is written into sum[16·idx+15:16·idx].
  - carry is updated with the chunk carry-out, and idx increments.
- Completing edge (idx==NCHUNK−1):
  - Go to IDLE; busy=0, done=1.
  - cout = final chunk carry-out; ovf updated.
- start while busy: ignored, with no queuing; operands and sub are not re-sampled.
- start during the done cycle: accepted, because the state is already IDLE. done falls and busy rises on the same edge.
- Outputs after the operation:
  - sum, cout and ovf hold their values until the next accepted start.
  - sum bits are overwritten chunk-by-chunk during RUN. sum is only guaranteed correct while done=1 and in the idle cycles after it.
- Arithmetic is modulo 2^WIDTH; there is no saturation.

## Timing
- Latency: start accepted at edge T → done=1 during the cycle after edge T+NCHUNK (4 cycles for WIDTH=64).
- Throughput: one operation per NCHUNK cycles, with back-to-back operations allowed via start in the done cycle.
- WIDTH=16: RUN lasts one edge; done follows edge T+1.
- Critical path: one 16-bit two-level lookahead (4 group generate/propagate → second-level lookahead → sums) plus the carry register mux; it does not scale with WIDTH.
- Reset mid-RUN: outputs go to 0 immediately (asynchronously). The first start after reset deassertion behaves normally.

## Configuration
- OVF_DETECT_EN defined:
  - ovf = carry into bit 15 XOR carry out of bit 15 of the final chunk, registered on the completing edge.
  - This is valid for both add and sub.
- OVF_DETECT_EN undefined:
  - ovf is tied to 0 and the bit-15 carry tap is not generated.
  - The port remains present.

## Structure
- Shared package:
  - CHUNK_W=16
  - GROUP_W=4
  - state enum {IDLE, RUN}
  - idx width function clog2(NCHUNK)
- One sub-module, cla16_chunk:
  - inputs: 16-bit x, 16-bit y, cin
  - outputs: 16-bit s, cout, c15
  - built from four 4-bit generate/propagate groups plus a second-level lookahead carry unit
  - purely combinational
- The controller holds the FSM, operand registers, index counter, carry register and result register.

## Test plan
- a=64'hFFFF_FFFF_FFFF_FFFF, b=1, sub=0 → sum=0, cout=1, ovf=0, done exactly 4 cycles after accept, busy high for those 4 cycles.
- a=5, b=7, sub=1 → sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0 (borrow).
- a=64'h7FFF_FFFF_FFFF_FFFF, b=1, sub=0 → sum=64'h8000_0000_0000_0000, cout=0. ovf=1 with OVF_DETECT_EN, ovf=0 without.
- Start with a=1, b=2, then start with a=9, b=9 two cycles later while busy → the second start is ignored; sum=3 with a single done pulse.
- Assert rst after the second chunk edge → busy=0, done=0, sum=0 immediately, no done pulse. A new start with a=10, b=20 then gives sum=30.
- Start during the done cycle with a=100, b=1 → done falls and busy rises on the same edge; the second done comes 4 cycles later with sum=101.
